lz77_bit_packer: RTL

LZ77_BIT_PACKER -- requirements
Module: lz77_bit_packer

---
 rtl/lz77_bit_packer_pkg.sv | 27 ++
 rtl/lz77_bit_packer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/lz77_bit_packer_pkg.sv
// Shared deflate definitions: block header, one-hot packer states,
// and the MSB-first field reversal helper.
package lz77_bit_packer_pkg;

    localparam logic [2:0] DEFLATE_HDR = 3'b011;

    localparam int IDLE_B  = 0;
    localparam int RUN_B   = 1;
    localparam int FLUSH_B = 2;
    localparam int DONE_B  = 3;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        RUN   = 4'b0010,
        FLUSH = 4'b0100,
        DONE  = 4'b1000
    } pack_state_e;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = d[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/lz77_bit_packer.sv
// Deflate bit packer: appends MSB-first code fields to a 64-bit
// accumulator and emits little-endian 32-bit words per block.
module lz77_bit_packer
    import lz77_bit_packer_pkg::*;
#(
    parameter int         OUT_WIDTH = 32,
    parameter logic [2:0] HDR_BITS  = DEFLATE_HDR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [5:0]           in_size,
    input  logic [OUT_WIDTH-1:0] in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [2:0]           out_bytes,
    output logic                 out_last,
    output logic                 overflow_err,
    output logic [31:0]          byte_count
);

    pack_state_e state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [6:0]  fill_q, fill_d;
    logic [5:0]  sz;
    logic [63:0] field;
    logic        out_fire;
    logic        take;
    logic        take_last;

    // Reversed field lands right-aligned: bit in_size-1 at position 0.
    always_comb begin
        sz    = (in_size > 6'd32) ? 6'd32 : in_size;
        field = {32'd0, bit_reverse32(in_data)} >> (7'd32 - {1'b0, sz});
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bytes = 3'd0;
        out_last  = 1'b0;
        unique case (1'b1)
            state_q[IDLE_B], state_q[DONE_B]: begin
                in_ready = 1'b1;
            end
            state_q[RUN_B]: begin
                out_valid = (fill_q >= 7'd32);
                out_bytes = out_valid ? 3'd4 : 3'd0;
                in_ready  = (fill_q <= 7'd31) | (out_valid & out_ready);
            end
            state_q[FLUSH_B]: begin
                out_valid = 1'b1;
                if (fill_q > 7'd32) begin
                    out_bytes = 3'd4;
                end else begin
                    out_last = 1'b1;
                    // An empty tail still closes the block with one pad byte.
                    out_bytes = (fill_q == 7'd0) ? 3'd1
                              : 3'((fill_q + 7'd7) >> 3);
                end
            end
            default: ;
        endcase
    end

    assign out_data  = out_valid ? acc_q[31:0] : '0;
    assign out_fire  = out_valid & out_ready;
    assign take      = in_valid & in_ready;
    assign take_last = in_last & in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        unique case (1'b1)
            state_q[IDLE_B], state_q[DONE_B]: begin
                if (in_valid | in_last) begin
                    acc_d  = {61'd0, HDR_BITS};
                    fill_d = 7'd3;
                    if (in_valid) begin
                        acc_d  = acc_d | (field << 3);
                        fill_d = 7'd3 + {1'b0, sz};
                    end
                    state_d = in_last ? FLUSH : RUN;
                end else if (state_q[DONE_B]) begin
                    acc_d   = '0;
                    fill_d  = '0;
                    state_d = IDLE;
                end
            end
            state_q[RUN_B]: begin
                if (out_fire) begin
                    acc_d  = acc_q >> 32;
                    fill_d = fill_q - 7'd32;
                end
                if (take) begin
                    acc_d  = acc_d | (field << fill_d);
                    fill_d = fill_d + {1'b0, sz};
                end
                if (take_last) begin
                    state_d = FLUSH;
                end
            end
            state_q[FLUSH_B]: begin
                if (out_fire) begin
                    if (fill_q > 7'd32) begin
                        acc_d  = acc_q >> 32;
                        fill_d = fill_q - 7'd32;
                    end else begin
                        acc_d   = '0;
                        fill_d  = '0;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            fill_q       <= '0;
            overflow_err <= 1'b0;
            byte_count   <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            overflow_err <= overflow_err | (in_valid & ~in_ready);
            if (out_fire) begin
                byte_count <= byte_count + {29'd0, out_bytes};
            end
        end
    end

endmodule
